// File: rtl/trigger_pulse_gen.sv
// Turns a 1-cycle trigger strobe into a delayed pulse with a programmable width,
// followed by a holdoff window. Triggers that arrive while busy are counted as missed.
module trigger_pulse_gen #(
    parameter int CNT_W  = 16,
    parameter int MISS_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trigger,
    input  logic [CNT_W-1:0]  delay_cfg,
    input  logic [CNT_W-1:0]  width_cfg,
    input  logic [CNT_W-1:0]  holdoff_cfg,
    input  logic              clr_missed,
    output logic              pulse_out,
    output logic              busy,
    output logic              missed,
    output logic [MISS_W-1:0] missed_cnt
);

    typedef enum logic [1:0] {IDLE, DELAY, HIGH, HOLDOFF} state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] w_lat;
    logic [CNT_W-1:0] h_lat;
    logic [CNT_W-1:0] w_in;
    logic             reject;

    // A width of zero is widened to one so every accepted trigger produces a pulse.
    assign w_in   = (width_cfg == '0) ? ONE : width_cfg;
    assign reject = trigger && (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            w_lat      <= '0;
            h_lat      <= '0;
            pulse_out  <= 1'b0;
            busy       <= 1'b0;
            missed     <= 1'b0;
            missed_cnt <= '0;
        end else begin
            missed <= reject;
            if (clr_missed)
                missed_cnt <= '0;
            else if (reject && (missed_cnt != '1))
                missed_cnt <= missed_cnt + MISS_W'(1);

            // cnt holds the number of remaining cycles in the current state minus one,
            // so full-scale configuration values never need an extra counter bit.
            case (state)
                IDLE: begin
                    if (trigger) begin
                        w_lat <= w_in;
                        h_lat <= holdoff_cfg;
                        busy  <= 1'b1;
                        if (delay_cfg != '0) begin
                            state <= DELAY;
                            cnt   <= delay_cfg - ONE;
                        end else begin
                            state     <= HIGH;
                            pulse_out <= 1'b1;
                            cnt       <= w_in - ONE;
                        end
                    end
                end
                DELAY: begin
                    if (cnt == '0) begin
                        state     <= HIGH;
                        pulse_out <= 1'b1;
                        cnt       <= w_lat - ONE;
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
                HIGH: begin
                    if (cnt == '0) begin
                        pulse_out <= 1'b0;
                        if (h_lat != '0) begin
                            state <= HOLDOFF;
                            cnt   <= h_lat - ONE;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
                HOLDOFF: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    pulse_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trigger_pulse_gen.sv
// Directed and randomized bench for trigger_pulse_gen, checked against a
// cycle-window reference model (pulse interval and busy horizon per accepted trigger).
module tb_trigger_pulse_gen;

    localparam int CNT_W  = 10;
    localparam int MISS_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              trigger;
    logic [CNT_W-1:0]  delay_cfg;
    logic [CNT_W-1:0]  width_cfg;
    logic [CNT_W-1:0]  holdoff_cfg;
    logic              clr_missed;
    logic              pulse_out;
    logic              busy;
    logic              missed;
    logic [MISS_W-1:0] missed_cnt;

    trigger_pulse_gen #(.CNT_W(CNT_W), .MISS_W(MISS_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .trigger    (trigger),
        .delay_cfg  (delay_cfg),
        .width_cfg  (width_cfg),
        .holdoff_cfg(holdoff_cfg),
        .clr_missed (clr_missed),
        .pulse_out  (pulse_out),
        .busy       (busy),
        .missed     (missed),
        .missed_cnt (missed_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: t is the index of the cycle whose inputs are being applied.
    longint t = 0;
    longint pulse_s = 1, pulse_e = 0, busy_until = -1;
    int     m_cnt = 0;
    bit     m_missed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, t, obs, exp);
        end
    endtask

    task automatic step(input bit trg, input bit clr, input bit r);
        longint d, w, h;
        bit rej;
        trigger    = trg;
        clr_missed = clr;
        rst        = r;
        d = longint'(delay_cfg);
        w = (width_cfg == 0) ? 1 : longint'(width_cfg);
        h = longint'(holdoff_cfg);
        @(posedge clk);
        #1;
        rej = 0;
        if (r) begin
            pulse_s = 1; pulse_e = 0; busy_until = -1;
            m_cnt = 0; m_missed = 0;
        end else begin
            if (trg && t > busy_until) begin
                pulse_s    = t + d + 1;
                pulse_e    = t + d + w;
                busy_until = t + d + w + h;
            end else if (trg) begin
                rej = 1;
            end
            m_missed = rej;
            if (clr) m_cnt = 0;
            else if (rej && m_cnt < 255) m_cnt++;
        end
        t++;
        chk("pulse_out", 32'(pulse_out), 32'(t >= pulse_s && t <= pulse_e));
        chk("busy", 32'(busy), 32'(t <= busy_until));
        chk("missed", 32'(missed), 32'(m_missed));
        chk("missed_cnt", 32'(missed_cnt), 32'(m_cnt));
    endtask

    task automatic cfg(input int d, input int w, input int h);
        delay_cfg   = CNT_W'(d);
        width_cfg   = CNT_W'(w);
        holdoff_cfg = CNT_W'(h);
    endtask

    initial begin
        trigger = 0; clr_missed = 0; rst = 1;
        cfg(0, 0, 0);

        // Reset state
        step(0, 0, 1);
        step(0, 0, 1);
        for (int i = 0; i < 8; i++) step(0, 0, 0);

        // Basic delayed pulse
        cfg(3, 4, 2);
        step(1, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 0, 0);

        // Minimal settings, two separated triggers
        cfg(0, 0, 0);
        step(1, 0, 0); step(0, 0, 0); step(1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0);

        // Held trigger: rejection counting and re-acceptance after holdoff
        cfg(2, 5, 3);
        for (int i = 0; i < 12; i++) step(1, 0, 0);
        for (int i = 0; i < 14; i++) step(0, 0, 0);
        step(0, 1, 0);

        // H=0 back-to-back: trigger in last HIGH cycle rejected, next one accepted
        cfg(0, 2, 0);
        for (int i = 0; i < 7; i++) step(1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0);

        // Saturation, then clear racing a rejection
        cfg(0, 400, 0);
        for (int i = 0; i < 301; i++) step(1, 0, 0);
        step(1, 1, 0);
        step(1, 0, 0);
        step(0, 1, 0);
        step(0, 0, 1);

        // Reset in the 2nd HIGH cycle, then normal acceptance
        cfg(1, 8, 0);
        step(1, 0, 0); step(0, 0, 0); step(0, 0, 0);
        step(0, 0, 1);
        step(1, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 0, 0);

        // Config change during DELAY applies only to the following trigger
        cfg(1, 3, 0);
        step(1, 0, 0);
        cfg(1, 10, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0);
        step(1, 0, 0);
        for (int i = 0; i < 14; i++) step(0, 0, 0);

        // Full-scale delay and width, with a trigger near the end of HIGH
        cfg((1 << CNT_W) - 1, (1 << CNT_W) - 1, 1);
        step(1, 0, 0);
        for (int i = 0; i < 2044; i++) step(0, 0, 0);
        step(1, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0);

        // Randomized traffic with small settings
        for (int i = 0; i < 3000; i++) begin
            cfg(int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
            step($urandom_range(0, 9) < 4, $urandom_range(0, 19) == 0, $urandom_range(0, 199) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
